// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg -- shared constants for the load/store unit controller.
// Holds the FSM state encoding, the 6-bit load/store opcodes, the
// byte-lane write-enable patterns and small decode helpers used by
// lsu_ctrl and lsu_ctrl_load_ext. No ports (package).
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Opcodes (MIPS primary-opcode values).
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  // Byte-lane write enables, lane k carries byte k of the word.
  localparam logic [3:0] WEA_NONE    = 4'b0000;
  localparam logic [3:0] WEA_LO_HALF = 4'b0011;
  localparam logic [3:0] WEA_HI_HALF = 4'b1100;
  localparam logic [3:0] WEA_WORD    = 4'b1111;

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load = 1'b1;
      default:                             is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: is_store = 1'b1;
      default:             is_store = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: misaligned = a[0];
      OP_LW, OP_SW:         misaligned = |a;
      default:              misaligned = 1'b0;
    endcase
  endfunction

  // Low address bits with the misaligned part forced to zero.
  function automatic logic [1:0] align_low(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: align_low = {a[1], 1'b0};
      OP_LW, OP_SW:         align_low = 2'b00;
      default:              align_low = a;
    endcase
  endfunction

  function automatic logic [3:0] store_wea(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_SB:   store_wea = 4'b0001 << a;
      OP_SH:   store_wea = a[1] ? WEA_HI_HALF : WEA_LO_HALF;
      OP_SW:   store_wea = WEA_WORD;
      default: store_wea = WEA_NONE;
    endcase
  endfunction

  // Store data replicated across lanes so the enabled lanes see the right bytes.
  function automatic logic [31:0] store_wdata(input logic [5:0] op, input logic [31:0] d);
    case (op)
      OP_SB:   store_wdata = {4{d[7:0]}};
      OP_SH:   store_wdata = {2{d[15:0]}};
      OP_SW:   store_wdata = d;
      default: store_wdata = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if -- request, RAM and response signals of the LSU controller.
// slave modport: the controller. master modport: the EX stage / RAM side.
//
// Handshake: a request transfers on a rising clk edge where req_valid=1,
// req_ready=1 and flush=0. req_ready depends only on controller state, never
// on req_valid. resp_valid is a one-cycle pulse with no back-pressure.
// mem_en/mem_wea/mem_addr/mem_wdata are valid only while mem_en=1;
// mem_rdata is expected one cycle after the mem_en cycle.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic        mem_en;
  logic [3:0]  mem_wea;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        exc_adel;
  logic        exc_ades;
  logic [31:0] badvaddr;
  logic        stall;

  modport slave (
    input  req_valid, op, addr, wdata, flush, mem_rdata,
    output req_ready, mem_en, mem_wea, mem_addr, mem_wdata,
           resp_valid, resp_data, exc_adel, exc_ades, badvaddr, stall
  );

  modport master (
    output req_valid, op, addr, wdata, flush, mem_rdata,
    input  req_ready, mem_en, mem_wea, mem_addr, mem_wdata,
           resp_valid, resp_data, exc_adel, exc_ades, badvaddr, stall
  );
endinterface

// File: rtl/lsu_ctrl_load_ext.sv
// lsu_ctrl_load_ext -- combinational load-result extraction.
// Ports: op_i (opcode), addr_i (byte offset in word), rdata_i (RAM word),
//        data_o (selected byte/halfword sign- or zero-extended, or full word;
//        0 for non-load opcodes).
module lsu_ctrl_load_ext
  import lsu_ctrl_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (op_i)
      OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data_o = {24'h0, byte_sel};
      OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data_o = {16'h0, half_sel};
      OP_LW:   data_o = rdata_i;
      default: data_o = 32'h0;
    endcase
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store unit controller, FSM IDLE -> ISSUE -> WAIT -> RESP.
// Ports: clk, resetn (synchronous, active low), bus (lsu_ctrl_if.slave:
//        request, RAM port, response, exceptions, stall), state_o (FSM state).
// Option macro LSU_ALIGN_EXC_EN: misaligned accesses raise exc_adel/exc_ades
// with badvaddr instead of having their low address bits forced to zero.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  lsu_ctrl_if.slave  bus,
  output lsu_state_e state_o
);
  lsu_state_e  state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        exc_q, exc_d;
  logic [31:0] ext_data;
  logic        issue, resp_fire;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.op;
          wdata_d = bus.wdata;
`ifdef LSU_ALIGN_EXC_EN
          addr_d  = bus.addr;
          exc_d   = misaligned(bus.op, bus.addr[1:0]);
          // Misaligned and unsupported requests skip the RAM entirely.
          state_d = ((is_load(bus.op) || is_store(bus.op)) && !exc_d) ? ST_ISSUE : ST_RESP;
`else
          addr_d  = {bus.addr[31:2], align_low(bus.op, bus.addr[1:0])};
          exc_d   = 1'b0;
          state_d = (is_load(bus.op) || is_store(bus.op)) ? ST_ISSUE : ST_RESP;
`endif
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        rdata_d = bus.mem_rdata;
        state_d = ST_RESP;
      end
      default:  state_d = ST_IDLE;
    endcase
    // Flush wins over everything, including a request arriving in IDLE.
    if (bus.flush) state_d = ST_IDLE;
  end

  lsu_ctrl_load_ext u_load_ext (
    .op_i    (op_q),
    .addr_i  (addr_q[1:0]),
    .rdata_i (rdata_q),
    .data_o  (ext_data)
  );

  assign issue     = (state_q == ST_ISSUE);
  // A flush in RESP cancels the response pulse.
  assign resp_fire = (state_q == ST_RESP) && !bus.flush;

  // Gated by resetn so every output reads 0 while reset is held.
  assign bus.req_ready = resetn && (state_q == ST_IDLE);
  assign bus.stall     = resetn && ((state_q != ST_IDLE) || bus.req_valid);

  // A write already in ISSUE is not affected by flush.
  assign bus.mem_en    = issue;
  assign bus.mem_wea   = issue ? store_wea(op_q, addr_q[1:0]) : WEA_NONE;
  assign bus.mem_addr  = issue ? addr_q[17:2] : 16'h0;
  assign bus.mem_wdata = issue ? store_wdata(op_q, wdata_q) : 32'h0;

  assign bus.resp_valid = resp_fire;
  assign bus.resp_data  = (resp_fire && is_load(op_q) && !exc_q) ? ext_data : 32'h0;

`ifdef LSU_ALIGN_EXC_EN
  assign bus.exc_adel = resp_fire && exc_q && is_load(op_q);
  assign bus.exc_ades = resp_fire && exc_q && !is_load(op_q);
  assign bus.badvaddr = (resp_fire && exc_q) ? addr_q : 32'h0;
`else
  assign bus.exc_adel = 1'b0;
  assign bus.exc_ades = 1'b0;
  assign bus.badvaddr = 32'h0;
  // Upper address bits only matter for badvaddr.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[31:18];
`endif

  assign state_o = state_q;
endmodule
